reg_bank32: RTL
===============

Name: reg_bank32

Overview:
Storage array of 32 general registers. It feeds the register-file read-port multiplexers: its Q0..Q31 outputs connect directly to the I0..I31 inputs of each 32:1 read mux. It has one write port with a valid/ready handshake and a hardware clear sequencer that zeroes the array one register per cycle.

Parameters:
WIDTH, 32, data width of each register and of wr_data / Q outputs
R0_ZERO, 1, when 1 register 0 is hardwired to zero and writes to address 0 are dropped

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
wr_valid  input  1  write request
wr_ready  output  1  write accepted when wr_valid & wr_ready at clk edge
wr_addr  input  5  destination register index
wr_data  input  WIDTH  write data
clr_req  input  1  request full-array clear (level, sampled)
busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse on the final clear cycle
wr_err  output  1  one-cycle pulse: accepted write to address 0 while R0_ZERO=1
Q0..Q31  output  WIDTH each  current register contents, flat buses to read muxes

Behaviour:
- Reset: clk edge with rst_n=0 sets all 32 registers to 0, state IDLE, clear counter 0, busy=0, clr_done=0, wr_err=0. wr_ready=1 from the first cycle after reset. Reset has priority over all other inputs.
- Interface: synchronous, active-low reset, single clock domain (clk, rst_n). No other clocks.
- Q outputs are direct register outputs, with no combinational path from wr_*. A write is visible on Q the cycle after acceptance (latency 1). There is no write-through bypass; forwarding is the consumer's job.
- wr_ready = (state == IDLE), combinational from state only. It does not depend on wr_valid.
- Write accept: wr_valid & wr_ready at an edge causes reg[wr_addr] <= wr_data. With wr_valid=0 or wr_ready=0, no state change to the array.
- R0_ZERO=1: reg[0] stays 0 permanently. An accepted write to addr 0 is dropped and wr_err pulses for 1 cycle. R0_ZERO=0: reg[0] is an ordinary register and wr_err stays 0.
- FSM states:
  - IDLE: clr_req=1 at an edge moves to CLEAR with cnt<=0.
  - CLEAR: reg[cnt]<=0 and cnt<=cnt+1 each cycle. When cnt==31, return to IDLE.
- busy = (state == CLEAR).
- clr_done is registered and asserts in the cycle after the edge that zeroed reg[31]; this is the same cycle busy falls. Total clear duration is 32 busy cycles.
- Simultaneous wr_valid and clr_req in IDLE: the write is accepted on that edge and the clear starts on the same edge. The written register is zeroed later in the sequence.
- clr_req held or reasserted during CLEAR: ignored, with no restart. clr_req still high on return to IDLE: a new clear starts on the next edge. Consequently, a level-held clr_req yields back-to-back sequences with one IDLE cycle between them, in which a write may be accepted.
- Reset mid-clear: all registers 0, state IDLE, clr_done is not pulsed.
- cnt is 5 bits. Wrap from 31 to 0 coincides with the exit from CLEAR and must not produce an extra cycle.

Decomposition:
- Shared package: NUM_REGS=32, ADDR_W=5, state encoding constants ST_IDLE/ST_CLEAR.
- One natural sub-module, reg_cell: a WIDTH-bit register with synchronous active-low reset, write enable and synchronous zero. It is instantiated 32 times via generate, with cell 0 tied off when R0_ZERO=1.
- The write-address decoder and clear FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles after random writes -> all Q=0, busy=0, wr_ready=1, clr_done=0, wr_err=0.
- Write/readback: write 0xDEADBEEF to addr 5, then 0x12345678 to addr 31 on consecutive cycles -> Q5=0xDEADBEEF one cycle after the first accept, Q31=0x12345678 one cycle after the second, other Q unchanged.
- R0: write 0xFFFFFFFF to addr 0 with R0_ZERO=1 -> Q0 stays 0, wr_err pulses exactly 1 cycle. Same with R0_ZERO=0 -> Q0=0xFFFFFFFF, wr_err=0.
- Clear: fill all regs with index+1, pulse clr_req 1 cycle -> busy high for exactly 32 cycles, wr_ready low for the same 32 cycles, Qn=0 after the (n+1)th busy edge, all Q=0 and clr_done=1 in the cycle busy falls.
- Simultaneous/ignored: in IDLE assert wr_valid (addr 3, 0xA5A5A5A5) and clr_req together -> write accepted, Q3=0xA5A5A5A5 until zeroed on the 4th clear cycle. wr_valid held during CLEAR -> not accepted. clr_req pulse mid-clear -> total busy still 32 cycles.
- Reset mid-clear: rst_n=0 at clear cycle 10 -> next cycle busy=0, all Q=0, no clr_done. A subsequent write to addr 7 is accepted immediately.

Source files
------------

// File: rtl/reg_bank32_pkg.sv
// reg_bank32_pkg: shared sizes and clear-FSM state encoding for the register bank.
package reg_bank32_pkg;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
endpackage

// File: rtl/reg_bank32_reg_cell.sv
// reg_cell: one register with sync active-low reset, write enable and sync zero.
module reg_cell #(
   parameter int WIDTH    = 32,
   parameter bit TIE_ZERO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] val_q, val_d;
   // A tied-off cell never leaves zero, so it folds away to a constant.
   always_comb val_d = (clr || TIE_ZERO) ? '0 : we ? d : val_q;
   always_ff @(posedge clk) begin
      if (!rst_n) val_q <= '0;
      else        val_q <= val_d;
   end
   assign q = val_q;
endmodule

// File: rtl/reg_bank32.sv
// reg_bank32: 32-entry register storage with a handshaked write port and a
// one-register-per-cycle hardware clear sequencer.
module reg_bank32
   import reg_bank32_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int R0_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   output logic              wr_err,
   output logic [WIDTH-1:0]  Q0,  Q1,  Q2,  Q3,  Q4,  Q5,  Q6,  Q7,
   output logic [WIDTH-1:0]  Q8,  Q9,  Q10, Q11, Q12, Q13, Q14, Q15,
   output logic [WIDTH-1:0]  Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
   output logic [WIDTH-1:0]  Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_done_q, clr_done_d;
   logic              wr_err_q, wr_err_d;
   logic              accept, last;
   logic [WIDTH-1:0]  q [NUM_REGS];

   assign wr_ready = (state_q == ST_IDLE);
   assign busy     = (state_q == ST_CLEAR);
   assign clr_done = clr_done_q;
   assign wr_err   = wr_err_q;
   assign accept   = wr_valid && wr_ready;
   assign last     = (cnt_q == ADDR_W'(NUM_REGS - 1));

   always_comb begin
      state_d    = (state_q == ST_IDLE) ? (clr_req ? ST_CLEAR : ST_IDLE) : (last ? ST_IDLE : ST_CLEAR);
      cnt_d      = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
      clr_done_d = busy && last;
      wr_err_d   = accept && (wr_addr == '0) && (R0_ZERO != 0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         clr_done_q <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_done_q <= clr_done_d;
         wr_err_q   <= wr_err_d;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
      reg_cell #(.WIDTH(WIDTH), .TIE_ZERO(i == 0 && R0_ZERO != 0)) u_cell (
         .clk  (clk),
         .rst_n(rst_n),
         .we   (accept && wr_addr == ADDR_W'(i)),
         .clr  (busy && cnt_q == ADDR_W'(i)),
         .d    (wr_data),
         .q    (q[i])
      );
   end

   assign Q0  = q[0];  assign Q1  = q[1];  assign Q2  = q[2];  assign Q3  = q[3];
   assign Q4  = q[4];  assign Q5  = q[5];  assign Q6  = q[6];  assign Q7  = q[7];
   assign Q8  = q[8];  assign Q9  = q[9];  assign Q10 = q[10]; assign Q11 = q[11];
   assign Q12 = q[12]; assign Q13 = q[13]; assign Q14 = q[14]; assign Q15 = q[15];
   assign Q16 = q[16]; assign Q17 = q[17]; assign Q18 = q[18]; assign Q19 = q[19];
   assign Q20 = q[20]; assign Q21 = q[21]; assign Q22 = q[22]; assign Q23 = q[23];
   assign Q24 = q[24]; assign Q25 = q[25]; assign Q26 = q[26]; assign Q27 = q[27];
   assign Q28 = q[28]; assign Q29 = q[29]; assign Q30 = q[30]; assign Q31 = q[31];
endmodule
